multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Multicycle signed ALU: single-cycle add/sub/logic ops, W-iteration shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module multicycle_alu #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [3:0]     ctrl,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           div0,
    output logic           illegal
);
    localparam int unsigned     CntW    = $clog2(W + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpMul  = 4'd2;
    localparam logic [3:0] OpDiv  = 4'd3;
    localparam logic [3:0] OpAnd  = 4'd4;
    localparam logic [3:0] OpOr   = 4'd5;
    localparam logic [3:0] OpUadd = 4'd6;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;       // mul: partial product; div: partial remainder
    logic [2*W-1:0]  mcand_q, mcand_d;   // mul: shifted multiplicand; div: divisor magnitude
    logic [W-1:0]    mplier_q, mplier_d; // mul: multiplier; div: dividend shifting into quotient
    logic [2*W-1:0]  result_q, result_d;
    logic            div0_q, div0_d, illegal_q, illegal_d;

    logic           accept, last_iter, res_neg;
    logic [W:0]     sum_s, dif_s, sum_u;
    logic [W-1:0]   and_r, or_r, a_mag, b_mag;
    logic [2*W-1:0] acc_next, mul_res, div_res;
    logic [W:0]     rem_sh, dsr, rem_new;
    logic           rem_ge;
    logic [W-1:0]   quo_new, q_fix, r_fix;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = (ctrl == OpMul || ctrl == OpDiv) ? StCalc : StDone;
                end
            end
            StCalc: begin
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        result    = result_q;
        div0      = div0_q;
        illegal   = illegal_q;
    end

    // Datapath
    always_comb begin
        accept    = (state_q == StIdle) && in_valid;
        last_iter = (cnt_q == CntLast);
        res_neg   = a_q[W-1] ^ b_q[W-1];

        sum_s = {a[W-1], a} + {b[W-1], b};
        dif_s = {a[W-1], a} - {b[W-1], b};
        sum_u = {1'b0, a} + {1'b0, b};
        and_r = a & b;
        or_r  = a | b;
        a_mag = a[W-1] ? (~a + 1'b1) : a;
        b_mag = b[W-1] ? (~b + 1'b1) : b;

        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_res  = res_neg ? (~acc_next + 1'b1) : acc_next;

        rem_sh  = {acc_q[W-1:0], mplier_q[W-1]};
        dsr     = {1'b0, mcand_q[W-1:0]};
        rem_ge  = (rem_sh >= dsr);
        rem_new = rem_ge ? (rem_sh - dsr) : rem_sh;
        quo_new = {mplier_q[W-2:0], rem_ge};
        q_fix   = res_neg ? (~quo_new + 1'b1) : quo_new;
        r_fix   = a_q[W-1] ? (~rem_new[W-1:0] + 1'b1) : rem_new[W-1:0];
        div_res = (b_q == '0) ? {a_q, {W{1'b1}}} : {r_fix, q_fix};

        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;
        div0_d    = div0_q;
        illegal_d = illegal_q;

        if (accept) begin
            a_d       = a;
            b_d       = b;
            ctrl_d    = ctrl;
            cnt_d     = '0;
            div0_d    = 1'b0;
            illegal_d = 1'b0;
            case (ctrl)
                OpAdd:  result_d = {{(W-1){sum_s[W]}}, sum_s};
                OpSub:  result_d = {{(W-1){dif_s[W]}}, dif_s};
                OpAnd:  result_d = {{W{and_r[W-1]}}, and_r};
                OpOr:   result_d = {{W{or_r[W-1]}}, or_r};
                OpUadd: result_d = {{(W-1){1'b0}}, sum_u};
                OpMul: begin
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, a_mag};
                    mplier_d = b_mag;
                end
                OpDiv: begin
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, b_mag};
                    mplier_d = a_mag;
                end
                default: begin
                    result_d  = '0;
                    illegal_d = 1'b1;
                end
            endcase
        end else if (state_q == StCalc) begin
            cnt_d = cnt_q + 1'b1;
            if (ctrl_q == OpDiv) begin
                acc_d    = {{(W-1){1'b0}}, rem_new};
                mplier_d = quo_new;
                if (last_iter) begin
                    result_d = div_res;
                    div0_d   = (b_q == '0);
                end
            end else begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (last_iter) begin
                    result_d = mul_res;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            result_q  <= '0;
            div0_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            result_q  <= result_d;
            div0_q    <= div0_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
